fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the 128-bit FIFO write port (wr / D_in) among N_REQ independent producers. Each producer offers beats on a valid/ready handshake. The arbiter grants one producer at a time for a locked burst and forwards accepted beats through one register stage onto the FIFO write port. It uses full and fifo_cnt to guarantee the FIFO is never written when it cannot accept. It sits directly in front of the FIFO write side, on the same clock as the FIFO.

---
 rtl/fifo_arb_pkg.sv | 28 ++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter:
//   - default parameter values (requester count, widths, FIFO depth, burst cap)
//   - arbiter state enumeration
//   - rr_start(): where the next round-robin search begins once a burst ends
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 128;
  localparam int CNT_W_DEF     = 256;
  localparam int DEPTH_DEF     = 16;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // The requester just served drops to lowest priority: the next search
  // starts one position after it, wrapping at n_req.
  function automatic int unsigned rr_start(input int unsigned granted,
                                           input int unsigned n_req);
    return (granted + 1) % n_req;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin selector: returns the first asserted request at or
// after i_ptr, wrapping around the request vector.
// Ports:
//   i_req    N_REQ   request vector
//   i_ptr    PTR_W   search start index
//   o_pick   N_REQ   one-hot selected requester (zero when none)
//   o_found  1       any request was selected
// -----------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_found
);

  logic [PTR_W-1:0] w_cand;

  // Walk the vector starting at i_ptr; the first hit wins and masks the rest.
  always_comb begin
    o_pick  = '0;
    o_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = PTR_W'((32'(i_ptr) + 32'(i)) % N_REQ);
      if (!o_found && i_req[w_cand]) begin
        o_pick[w_cand] = 1'b1;
        o_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// A producer is granted for a locked burst (ends on last or MAX_BURST beats);
// accepted beats pass through one register stage onto wr / D_in. Occupancy
// (fifo_cnt plus the beat already held in the output register) gates
// req_ready so the FIFO is never written beyond DEPTH.
// Ports:
//   clock      in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   req_valid  in   N_REQ         per-requester beat valid
//   req_last   in   N_REQ         per-requester last-beat flag
//   req_data   in   N_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  N_REQ         beat accepted when valid (granted only)
//   grant      out  N_REQ         one-hot registered owner, zero when idle
//   busy       out  1             burst in progress
//   wr         out  1             registered FIFO write strobe
//   D_in       out  DATA_W        registered FIFO write data
//   full       in   1             FIFO full flag
//   fifo_cnt   in   CNT_W         FIFO occupancy
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    wr,
  output logic [DATA_W-1:0]       D_in,
  input  logic                    full,
  input  logic [CNT_W-1:0]        fifo_cnt
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e        r_state;
  logic [N_REQ-1:0]  r_grant;
  logic [PTR_W-1:0]  r_gIdx;
  logic [PTR_W-1:0]  r_rrPtr;
  logic [BCNT_W-1:0] r_beatCnt;
  logic              r_wr;
  logic [DATA_W-1:0] r_din;

  logic [N_REQ-1:0]  w_pick;
  logic              w_found;
  logic [PTR_W-1:0]  w_pickIdx;
  logic [CNT_W:0]    w_occSum;
  logic              w_slotFree;
  logic [N_REQ-1:0]  w_ready;
  logic              w_accept;
  logic              w_lastBeat;
  logic              w_burstEnd;
  logic [DATA_W-1:0] w_gData;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rrPtr),
    .o_pick  (w_pick),
    .o_found (w_found)
  );

  // Binary index of the one-hot pick, kept alongside grant for muxing.
  always_comb begin
    w_pickIdx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) begin
        w_pickIdx = PTR_W'(i);
      end
    end
  end

  // The beat sitting in the output register lands next edge, so it counts
  // toward occupancy. One extra bit keeps the add from wrapping.
  assign w_occSum   = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, r_wr};
  assign w_slotFree = !full && (w_occSum < (CNT_W+1)'(DEPTH));

  assign w_ready    = ((r_state == BURST) && w_slotFree) ? r_grant : '0;
  assign w_accept   = |(req_valid & w_ready);
  assign w_gData    = req_data[int'(r_gIdx)*DATA_W +: DATA_W];
  assign w_lastBeat = req_last[r_gIdx];
  assign w_burstEnd = w_accept &&
                      (w_lastBeat || (r_beatCnt == BCNT_W'(MAX_BURST-1)));

  assign req_ready = w_ready;
  assign grant     = r_grant;
  assign busy      = (r_state == BURST);
  assign wr        = r_wr;
  assign D_in      = r_din;

  // Arbitration FSM: lock a grant in IDLE, count beats in BURST, release and
  // advance the round-robin pointer past the owner when the burst ends.
  // A valid drop keeps the grant and freezes the count.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_gIdx    <= '0;
      r_rrPtr   <= '0;
      r_beatCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beatCnt <= '0;
          if (w_found) begin
            r_grant <= w_pick;
            r_gIdx  <= w_pickIdx;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (w_accept) begin
            r_beatCnt <= r_beatCnt + BCNT_W'(1);
          end
          if (w_burstEnd) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_rrPtr <= PTR_W'(rr_start(32'(r_gIdx), N_REQ));
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Output register: one write per accepted beat; data holds between beats.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_wr  <= 1'b0;
      r_din <= '0;
    end else begin
      r_wr <= w_accept;
      if (w_accept) begin
        r_din <= w_gData;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model of
// the arbitration rules (owner index, beat count, round-robin pointer).
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 128;
  localparam int CW    = 256;
  localparam int DEPTH = 16;
  localparam int MB    = 8;

  logic            clock;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic            wr;
  logic [DW-1:0]   D_in;
  logic            full;
  logic [CW-1:0]   fifo_cnt;

  fifo_wr_arbiter dut (
    .clock     (clock),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant     (grant),
    .busy      (busy),
    .wr        (wr),
    .D_in      (D_in),
    .full      (full),
    .fifo_cnt  (fifo_cnt)
  );

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model: owner index (-1 when idle), beats taken in this burst,
  // round-robin start, and the contents of the output stage.
  int          mOwner;
  int          mBeats;
  int          mPtr;
  logic        mWr;
  logic [DW-1:0] mData;

  // Bench-side FIFO occupancy used when the capacity scenario is active.
  bit          trackFifo;
  bit          readReq;
  int          occ;

  logic [N-1:0]  sampAcc;
  logic          sampWr;
  logic [N-1:0]  prevGrant;
  logic [DW-1:0] writes[$];
  logic [N-1:0]  grantStarts[$];

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setData(input int idx, input logic [DW-1:0] d);
    req_data[idx*DW +: DW] = d;
  endtask

  task automatic modelReset();
    mOwner = -1;
    mBeats = 0;
    mPtr   = 0;
    mWr    = 1'b0;
    mData  = '0;
  endtask

  // Ready rule: owner only, FIFO not full, and occupancy including the
  // pending registered beat still below capacity.
  function automatic logic [N-1:0] modelReady();
    logic [CW:0] pending;
    pending = {1'b0, fifo_cnt} + (CW+1)'(mWr);
    if (mOwner >= 0 && !full && pending < (CW+1)'(DEPTH))
      return N'(1 << mOwner);
    return '0;
  endfunction

  task automatic modelStep(input logic [N-1:0] rdy);
    int idx;
    if (mOwner < 0) begin
      mWr = 1'b0;
      for (int i = 0; i < N; i++) begin
        idx = (mPtr + i) % N;
        if (mOwner < 0 && req_valid[idx]) begin
          mOwner = idx;
          mBeats = 0;
        end
      end
    end else if (req_valid[mOwner] && rdy[mOwner]) begin
      mWr    = 1'b1;
      mData  = req_data[mOwner*DW +: DW];
      mBeats = mBeats + 1;
      if (req_last[mOwner] || mBeats == MB) begin
        mPtr   = (mOwner + 1) % N;
        mOwner = -1;
      end
    end else begin
      mWr = 1'b0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then return 1 time unit after it so new inputs are set away from it.
  task automatic stepCycle();
    logic [N-1:0] expReady;
    logic [N-1:0] expGrant;
    @(negedge clock);
    expReady = modelReady();
    expGrant = (mOwner >= 0) ? N'(1 << mOwner) : '0;
    checkOutput("req_ready", DW'(req_ready), DW'(expReady));
    checkOutput("grant", DW'(grant), DW'(expGrant));
    checkOutput("busy", DW'(busy), DW'(mOwner >= 0));
    checkOutput("wr", DW'(wr), DW'(mWr));
    checkOutput("D_in", D_in, mData);
    if (trackFifo)
      checkOutput("no_overflow", DW'(wr && fifo_cnt >= CW'(DEPTH)), '0);
    sampAcc = req_valid & req_ready;
    sampWr  = wr;
    if (wr) writes.push_back(D_in);
    if (grant != '0 && prevGrant == '0) grantStarts.push_back(grant);
    prevGrant = grant;
    @(posedge clock);
    modelStep(expReady);
    if (trackFifo) begin
      occ = occ + int'(sampWr);
      if (readReq && occ > 0) occ = occ - 1;
    end
    readReq = 1'b0;
    #1;
    if (trackFifo) fifo_cnt = CW'(occ);
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] last);
    req_valid = valid;
    req_last  = last;
    stepCycle();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge; release
  // lands between edges.
  task automatic doReset();
    rst = 1'b0;
    #2;
    modelReset();
    checkOutput("rst_grant", DW'(grant), '0);
    checkOutput("rst_busy", DW'(busy), '0);
    checkOutput("rst_wr", DW'(wr), '0);
    checkOutput("rst_D_in", D_in, '0);
    checkOutput("rst_req_ready", DW'(req_ready), '0);
    @(posedge clock);
    #3;
    rst = 1'b1;
    prevGrant = '0;
  endtask

  logic [DW-1:0] beatVals[3];
  int k;
  int acc;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    full      = 1'b0;
    fifo_cnt  = '0;
    trackFifo = 1'b0;
    readReq   = 1'b0;
    occ       = 0;
    prevGrant = '0;
    modelReset();
    #1;
    doReset();

    // Single burst from req0: A, B, C with last on C.
    $display("[TB] single burst");
    beatVals[0] = DW'(32'hA);
    beatVals[1] = DW'(32'hB);
    beatVals[2] = DW'(32'hC);
    writes.delete();
    setData(0, beatVals[0]);
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("single_grant", DW'(grant), DW'(4'b0001));
    k = 0;
    for (int g = 0; g < 20 && k < 3; g++) begin
      applyStimulus(4'b0001, (k == 2) ? 4'b0001 : 4'b0000);
      if (sampAcc[0]) begin
        k++;
        if (k < 3) setData(0, beatVals[k]);
      end
    end
    checkOutput("single_beats", DW'(k), DW'(3));
    for (int g = 0; g < 3; g++) applyStimulus(4'b0000, 4'b0000);
    checkOutput("single_nwrites", DW'(writes.size()), DW'(3));
    for (int j = 0; j < 3; j++)
      checkOutput("single_data", (writes.size() > j) ? writes[j] : 'x, beatVals[j]);
    checkOutput("single_idle_grant", DW'(grant), '0);
    applyStimulus(4'b0011, 4'b0000);
    checkOutput("rr_after_req0", DW'(grant), DW'(4'b0010));

    // Fairness: everyone valid, no last; bursts capped at MB beats.
    $display("[TB] fairness");
    doReset();
    for (int i = 0; i < N; i++) setData(i, DW'(32'h1000 + i));
    writes.delete();
    grantStarts.delete();
    for (int g = 0; g < 48; g++) applyStimulus(4'b1111, 4'b0000);
    checkOutput("fair_nwrites_ge40", DW'(writes.size() >= 40), DW'(1));
    for (int j = 0; j < 40; j++)
      checkOutput("fair_beat", (writes.size() > j) ? writes[j] : 'x,
                  DW'(32'h1000 + (j / MB) % N));
    checkOutput("fair_ngrants_ge5", DW'(grantStarts.size() >= 5), DW'(1));
    for (int j = 0; j < 5; j++)
      checkOutput("fair_grant_order", (grantStarts.size() > j) ? DW'(grantStarts[j]) : 'x,
                  DW'(4'b0001 << (j % N)));

    // Capacity: FIFO nearly full, no reads; then one read frees one slot.
    $display("[TB] capacity");
    doReset();
    setData(2, DW'(32'hC0DE));
    trackFifo = 1'b1;
    occ       = DEPTH - 3;
    fifo_cnt  = CW'(occ);
    writes.delete();
    for (int g = 0; g < 10; g++) applyStimulus(4'b0100, 4'b0000);
    checkOutput("cap_fill_writes", DW'(writes.size()), DW'(3));
    checkOutput("cap_fill_occ", DW'(occ), DW'(DEPTH));
    checkOutput("cap_full_ready", DW'(req_ready), '0);
    readReq = 1'b1;
    applyStimulus(4'b0100, 4'b0000);
    for (int g = 0; g < 4; g++) applyStimulus(4'b0100, 4'b0000);
    checkOutput("cap_one_slot_writes", DW'(writes.size()), DW'(4));
    checkOutput("cap_one_slot_occ", DW'(occ), DW'(DEPTH));
    trackFifo = 1'b0;
    fifo_cnt  = '0;
    for (int g = 0; g < 20 && grant != '0; g++) applyStimulus(4'b0100, 4'b0000);
    for (int g = 0; g < 2; g++) applyStimulus(4'b0000, 4'b0000);
    checkOutput("cap_burst_total", DW'(writes.size()), DW'(MB));

    // Full pulsed for 3 cycles after beat 4 of a burst.
    $display("[TB] full mid-burst");
    setData(3, DW'(32'hF00D));
    writes.delete();
    acc = 0;
    for (int g = 0; g < 20 && acc < 4; g++) begin
      applyStimulus(4'b1000, 4'b0000);
      acc += int'(sampAcc[3]);
    end
    full = 1'b1;
    for (int g = 0; g < 3; g++) begin
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("full_no_accept", DW'(sampAcc), '0);
      acc += int'(sampAcc[3]);
    end
    full = 1'b0;
    for (int g = 0; g < 20 && grant != '0; g++) begin
      applyStimulus(4'b1000, 4'b0000);
      acc += int'(sampAcc[3]);
    end
    checkOutput("full_burst_total", DW'(acc), DW'(MB));
    for (int g = 0; g < 2; g++) applyStimulus(4'b0000, 4'b0000);
    checkOutput("full_nwrites", DW'(writes.size()), DW'(MB));

    // Reset while req2 owns the port with a write in flight.
    $display("[TB] reset mid-burst");
    setData(2, DW'(32'hBEEF));
    for (int g = 0; g < 10 && !wr; g++) applyStimulus(4'b0100, 4'b0000);
    checkOutput("rst_pre_wr", DW'(wr), DW'(1));
    req_valid = 4'b1111;
    doReset();
    applyStimulus(4'b1111, 4'b0000);
    checkOutput("rst_first_grant", DW'(grant), DW'(4'b0001));

    // Valid drop: req1 pauses after 2 beats while req3 waits.
    $display("[TB] valid drop");
    doReset();
    setData(1, DW'(32'h11));
    setData(3, DW'(32'h33));
    acc = 0;
    for (int g = 0; g < 10 && acc < 2; g++) begin
      applyStimulus(4'b1010, 4'b0000);
      acc += int'(sampAcc[1]);
    end
    for (int g = 0; g < 3; g++) begin
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("drop_grant", DW'(grant), DW'(4'b0010));
      checkOutput("drop_ready3", DW'(req_ready[3]), '0);
    end
    for (int g = 0; g < 10 && grant != '0; g++) begin
      applyStimulus(4'b1010, 4'b0010);
      acc += int'(sampAcc[1]);
    end
    checkOutput("drop_total", DW'(acc), DW'(3));
    for (int g = 0; g < 5 && grant == '0; g++) applyStimulus(4'b1000, 4'b0000);
    checkOutput("drop_next_grant", DW'(grant), DW'(4'b1000));

    // Randomized traffic against the model.
    $display("[TB] random");
    doReset();
    for (int g = 0; g < 400; g++) begin
      for (int i = 0; i < N; i++)
        setData(i, {$urandom, $urandom, $urandom, $urandom});
      full     = ($urandom_range(7) == 0);
      fifo_cnt = ($urandom_range(31) == 0) ? (CW'(1) << 200)
                                           : CW'($urandom_range(DEPTH));
      applyStimulus(N'($urandom),
                    {($urandom_range(3) == 0), ($urandom_range(3) == 0),
                     ($urandom_range(3) == 0), ($urandom_range(3) == 0)});
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
